// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit beside the ID stage: resolves each
// source operand and HI/LO from the EXE/MEM write ports, stalling on load-use.

module fwd_src_cmp #(
    parameter int ADDR_W = 5
) (
    input  logic              valid_i,
    input  logic              used_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              e_wena_i,
    input  logic [ADDR_W-1:0] e_waddr_i,
    input  logic              e_is_load_i,
    input  logic              m_wena_i,
    input  logic [ADDR_W-1:0] m_waddr_i,
    output logic              e_hit_o,
    output logic              load_hit_o,
    output logic              m_hit_o
);
    logic cand, e_match, m_match;

    // r0 is hard-wired zero, so it never takes a forwarded value.
    assign cand       = valid_i && used_i && (addr_i != '0);
    assign e_match    = cand && e_wena_i && (e_waddr_i == addr_i);
    assign m_match    = cand && m_wena_i && (m_waddr_i == addr_i);
    assign e_hit_o    = e_match && !e_is_load_i;
    assign load_hit_o = e_match && e_is_load_i;
    assign m_hit_o    = m_match && !e_match;
endmodule

module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic                      id_rd_hi_i,
    input  logic                      id_rd_lo_i,
    input  logic                      e_rf_wena_i,
    input  logic [ADDR_W-1:0]         e_rf_waddr_i,
    input  logic [DATA_W-1:0]         e_rf_wdata_i,
    input  logic                      e_is_load_i,
    input  logic                      e_hi_wena_i,
    input  logic [DATA_W-1:0]         e_hi_wdata_i,
    input  logic                      e_lo_wena_i,
    input  logic [DATA_W-1:0]         e_lo_wdata_i,
    input  logic                      m_rf_wena_i,
    input  logic [ADDR_W-1:0]         m_rf_waddr_i,
    input  logic [DATA_W-1:0]         m_rf_wdata_i,
    input  logic                      m_hi_wena_i,
    input  logic [DATA_W-1:0]         m_hi_wdata_i,
    input  logic                      m_lo_wena_i,
    input  logic [DATA_W-1:0]         m_lo_wdata_i,
    output logic [NUM_SRC-1:0]        fwd_valid_o,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data_o,
    output logic                      hi_fwd_o,
    output logic [DATA_W-1:0]         hi_o,
    output logic                      lo_fwd_o,
    output logic [DATA_W-1:0]         lo_o,
    output logic                      stall_o,
    output logic                      load_miss_o
);
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_SRC-1:0]               pend_q, pend_d;
    logic [ADDR_W-1:0]                laddr_q, laddr_d;
    logic [NUM_SRC-1:0]               fv_q, fv_d;
    logic [NUM_SRC-1:0][DATA_W-1:0]   fd_q, fd_d;
    logic                             hi_fwd_q, hi_fwd_d, lo_fwd_q, lo_fwd_d;
    logic [DATA_W-1:0]                hi_q, hi_d, lo_q, lo_d;
    logic                             stall_q, stall_d, miss_q, miss_d;

    logic [NUM_SRC-1:0]               e_hit, load_hit, m_hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_cmp #(.ADDR_W(ADDR_W)) u_cmp (
            .valid_i    (id_valid_i),
            .used_i     (id_src_used_i[g]),
            .addr_i     (id_src_addr_i[g*ADDR_W +: ADDR_W]),
            .e_wena_i   (e_rf_wena_i),
            .e_waddr_i  (e_rf_waddr_i),
            .e_is_load_i(e_is_load_i),
            .m_wena_i   (m_rf_wena_i),
            .m_waddr_i  (m_rf_waddr_i),
            .e_hit_o    (e_hit[g]),
            .load_hit_o (load_hit[g]),
            .m_hit_o    (m_hit[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        laddr_d  = laddr_q;
        fv_d     = fv_q;
        fd_d     = fd_q;
        hi_fwd_d = hi_fwd_q;
        hi_d     = hi_q;
        lo_fwd_d = lo_fwd_q;
        lo_d     = lo_q;
        stall_d  = stall_q;
        miss_d   = miss_q;
        case (state_q)
            IDLE: begin
                // Pending operands report valid now; their data lands at capture.
                for (int i = 0; i < NUM_SRC; i++) begin
                    fv_d[i] = e_hit[i] | load_hit[i] | m_hit[i];
                    if (e_hit[i])      fd_d[i] = e_rf_wdata_i;
                    else if (m_hit[i]) fd_d[i] = m_rf_wdata_i;
                end
                pend_d = load_hit;
                if (|load_hit) begin
                    stall_d = 1'b1;
                    cnt_d   = CNT_W'(LOAD_LAT - 1);
                    laddr_d = e_rf_waddr_i;
                    state_d = WAIT;
                end
                hi_fwd_d = id_valid_i && id_rd_hi_i && (e_hi_wena_i || m_hi_wena_i);
                if (id_valid_i && id_rd_hi_i) begin
                    if (e_hi_wena_i)      hi_d = e_hi_wdata_i;
                    else if (m_hi_wena_i) hi_d = m_hi_wdata_i;
                end
                lo_fwd_d = id_valid_i && id_rd_lo_i && (e_lo_wena_i || m_lo_wena_i);
                if (id_valid_i && id_rd_lo_i) begin
                    if (e_lo_wena_i)      lo_d = e_lo_wdata_i;
                    else if (m_lo_wena_i) lo_d = m_lo_wdata_i;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    for (int i = 0; i < NUM_SRC; i++)
                        if (pend_q[i]) fd_d[i] = m_rf_wdata_i;
                    if (!m_rf_wena_i || (m_rf_waddr_i != laddr_q)) miss_d = 1'b1;
                    pend_d  = '0;
                    stall_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            laddr_q  <= '0;
            fv_q     <= '0;
            fd_q     <= '0;
            hi_fwd_q <= 1'b0;
            hi_q     <= '0;
            lo_fwd_q <= 1'b0;
            lo_q     <= '0;
            stall_q  <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            laddr_q  <= laddr_d;
            fv_q     <= fv_d;
            fd_q     <= fd_d;
            hi_fwd_q <= hi_fwd_d;
            hi_q     <= hi_d;
            lo_fwd_q <= lo_fwd_d;
            lo_q     <= lo_d;
            stall_q  <= stall_d;
            miss_q   <= miss_d;
        end
    end

    assign fwd_valid_o = fv_q;
    assign fwd_data_o  = fd_q;
    assign hi_fwd_o    = hi_fwd_q;
    assign hi_o        = hi_q;
    assign lo_fwd_o    = lo_fwd_q;
    assign lo_o        = lo_q;
    assign stall_o     = stall_q;
    assign load_miss_o = miss_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a LOAD_LAT=1 and a LOAD_LAT=3 instance share stimulus;
// directed scenarios plus random traffic against a cycle-level reference model.

module tb_fwd_hazard_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int OW = 4 + NS + NS*DW + 2*DW;

    logic clk = 1'b0;
    logic rst;
    logic          id_valid;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0] id_src_used;
    logic          id_rd_hi, id_rd_lo;
    logic          e_rf_wena, e_is_load, e_hi_wena, e_lo_wena;
    logic [AW-1:0] e_rf_waddr;
    logic [DW-1:0] e_rf_wdata, e_hi_wdata, e_lo_wdata;
    logic          m_rf_wena, m_hi_wena, m_lo_wena;
    logic [AW-1:0] m_rf_waddr;
    logic [DW-1:0] m_rf_wdata, m_hi_wdata, m_lo_wdata;

    logic [NS-1:0]    fv_w [2];
    logic [NS*DW-1:0] fd_w [2];
    logic             hif_w [2], lof_w [2], stall_w [2], miss_w [2];
    logic [DW-1:0]    hi_w [2], lo_w [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state, index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 3.
    int               lat [2] = '{1, 3};
    int               left [2];
    logic [NS-1:0]    mpend [2], mfv [2];
    logic [NS*DW-1:0] mfd [2];
    logic [AW-1:0]    mladdr [2];
    logic             mhif [2], mlof [2], mstall [2], mmiss [2];
    logic [DW-1:0]    mhi [2], mlo [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        fwd_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(k == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .id_valid_i(id_valid), .id_src_addr_i(id_src_addr), .id_src_used_i(id_src_used),
            .id_rd_hi_i(id_rd_hi), .id_rd_lo_i(id_rd_lo),
            .e_rf_wena_i(e_rf_wena), .e_rf_waddr_i(e_rf_waddr), .e_rf_wdata_i(e_rf_wdata),
            .e_is_load_i(e_is_load),
            .e_hi_wena_i(e_hi_wena), .e_hi_wdata_i(e_hi_wdata),
            .e_lo_wena_i(e_lo_wena), .e_lo_wdata_i(e_lo_wdata),
            .m_rf_wena_i(m_rf_wena), .m_rf_waddr_i(m_rf_waddr), .m_rf_wdata_i(m_rf_wdata),
            .m_hi_wena_i(m_hi_wena), .m_hi_wdata_i(m_hi_wdata),
            .m_lo_wena_i(m_lo_wena), .m_lo_wdata_i(m_lo_wdata),
            .fwd_valid_o(fv_w[k]), .fwd_data_o(fd_w[k]),
            .hi_fwd_o(hif_w[k]), .hi_o(hi_w[k]), .lo_fwd_o(lof_w[k]), .lo_o(lo_w[k]),
            .stall_o(stall_w[k]), .load_miss_o(miss_w[k])
        );
    end

    // Advance the model with the inputs about to be sampled at the next edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                left[k] = 0; mpend[k] = '0; mfv[k] = '0; mfd[k] = '0; mladdr[k] = '0;
                mhif[k] = 0; mlof[k] = 0; mstall[k] = 0; mmiss[k] = 0; mhi[k] = '0; mlo[k] = '0;
            end else if (left[k] > 0) begin
                left[k] = left[k] - 1;
                if (left[k] == 0) begin
                    for (int i = 0; i < NS; i++)
                        if (mpend[k][i]) mfd[k][i*DW +: DW] = m_rf_wdata;
                    if (!(m_rf_wena && m_rf_waddr == mladdr[k])) mmiss[k] = 1;
                    mpend[k] = '0;
                    mstall[k] = 0;
                end
            end else begin
                mpend[k] = '0;
                for (int i = 0; i < NS; i++) begin
                    logic [AW-1:0] a;
                    logic cand;
                    a = id_src_addr[i*AW +: AW];
                    cand = id_valid && id_src_used[i] && a != 0;
                    if (cand && e_rf_wena && e_rf_waddr == a) begin
                        mfv[k][i] = 1;
                        if (e_is_load) mpend[k][i] = 1;
                        else mfd[k][i*DW +: DW] = e_rf_wdata;
                    end else if (cand && m_rf_wena && m_rf_waddr == a) begin
                        mfv[k][i] = 1;
                        mfd[k][i*DW +: DW] = m_rf_wdata;
                    end else begin
                        mfv[k][i] = 0;
                    end
                end
                if (mpend[k] != 0) begin
                    mstall[k] = 1; left[k] = lat[k]; mladdr[k] = e_rf_waddr;
                end
                mhif[k] = 0;
                if (id_valid && id_rd_hi && e_hi_wena) begin mhif[k] = 1; mhi[k] = e_hi_wdata; end
                else if (id_valid && id_rd_hi && m_hi_wena) begin mhif[k] = 1; mhi[k] = m_hi_wdata; end
                mlof[k] = 0;
                if (id_valid && id_rd_lo && e_lo_wena) begin mlof[k] = 1; mlo[k] = e_lo_wdata; end
                else if (id_valid && id_rd_lo && m_lo_wena) begin mlof[k] = 1; mlo[k] = m_lo_wdata; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 0; id_src_addr = '0; id_src_used = '0; id_rd_hi = 0; id_rd_lo = 0;
        e_rf_wena = 0; e_rf_waddr = '0; e_rf_wdata = '0; e_is_load = 0;
        e_hi_wena = 0; e_hi_wdata = '0; e_lo_wena = 0; e_lo_wdata = '0;
        m_rf_wena = 0; m_rf_waddr = '0; m_rf_wdata = '0;
        m_hi_wena = 0; m_hi_wdata = '0; m_lo_wena = 0; m_lo_wdata = '0;
    endtask

    task automatic do_reset();
        clr_in(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            obs = {stall_w[k], miss_w[k], fv_w[k], fd_w[k], hif_w[k], hi_w[k], lof_w[k], lo_w[k]};
            total_cnt++;
            if (obs !== '0) $display("FAIL reset_outputs[%0d] got %h want 0", k, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_alu_fwd();
        clr_in();
        e_rf_wena = 1; e_rf_waddr = 5'd3; e_rf_wdata = 32'h11;
        m_rf_wena = 1; m_rf_waddr = 5'd4; m_rf_wdata = 32'h22;
        id_valid = 1; id_src_addr = {5'd4, 5'd3}; id_src_used = 2'b11;
        tick();
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (fv_w[k] !== 2'b11) $display("FAIL alu_fwd_valid[%0d] got %b want 11", k, fv_w[k]);
            else pass_cnt++;
            total_cnt++;
            if (fd_w[k] !== {32'h22, 32'h11}) $display("FAIL alu_fwd_data[%0d] got %h want 0000002200000011", k, fd_w[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (stall_w[0] !== 1'b0) $display("FAIL alu_fwd_stall got %b want 0", stall_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        clr_in();
        e_rf_wena = 1; e_rf_waddr = 5'd5; e_rf_wdata = 32'hAA;
        m_rf_wena = 1; m_rf_waddr = 5'd5; m_rf_wdata = 32'hBB;
        id_valid = 1; id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        tick();
        total_cnt++;
        if (fv_w[0][0] !== 1'b1 || fd_w[0][31:0] !== 32'hAA)
            $display("FAIL prio_exe got v=%b d=%h want v=1 d=000000aa", fv_w[0][0], fd_w[0][31:0]);
        else pass_cnt++;
        e_rf_waddr = 5'd0; m_rf_waddr = 5'd0; id_src_addr = '0; id_src_used = 2'b11;
        tick();
        total_cnt++;
        if (fv_w[0] !== 2'b00) $display("FAIL prio_r0_valid got %b want 00", fv_w[0]);
        else pass_cnt++;
        total_cnt++;
        if (fd_w[0][31:0] !== 32'hAA) $display("FAIL prio_r0_hold got %h want 000000aa", fd_w[0][31:0]);
        else pass_cnt++;
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        e_rf_wena = 1; e_is_load = 1; e_rf_waddr = 5'd7; e_rf_wdata = 32'hBAD;
        id_valid = 1; id_src_addr = {5'd7, 5'd7}; id_src_used = 2'b11;
        tick();
        total_cnt++;
        if (stall_w[0] !== 1'b1 || fv_w[0] !== 2'b11)
            $display("FAIL lat1_detect got stall=%b v=%b want stall=1 v=11", stall_w[0], fv_w[0]);
        else pass_cnt++;
        e_rf_wena = 0; e_is_load = 0;
        m_rf_wena = 1; m_rf_waddr = 5'd7; m_rf_wdata = 32'hDEAD;
        tick();
        total_cnt++;
        if (stall_w[0] !== 1'b0) $display("FAIL lat1_release got stall=%b want 0", stall_w[0]);
        else pass_cnt++;
        total_cnt++;
        if (fd_w[0] !== {32'hDEAD, 32'hDEAD} || miss_w[0] !== 1'b0)
            $display("FAIL lat1_capture got d=%h miss=%b want d=0000dead0000dead miss=0", fd_w[0], miss_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_load_use_lat3();
        do_reset();
        e_rf_wena = 1; e_is_load = 1; e_rf_waddr = 5'd7;
        id_valid = 1; id_src_addr = {5'd2, 5'd7}; id_src_used = 2'b01;
        tick();
        e_rf_wena = 0; e_is_load = 0;
        // Decoy write to r7 before the capture edge must not be taken.
        m_rf_wena = 1; m_rf_waddr = 5'd7; m_rf_wdata = 32'h1111;
        for (int c = 1; c <= 3; c++) begin
            total_cnt++;
            if (stall_w[1] !== 1'b1) $display("FAIL lat3_stall_cycle%0d got %b want 1", c, stall_w[1]);
            else pass_cnt++;
            if (c == 3) m_rf_wdata = 32'hBEEF;
            tick();
        end
        total_cnt++;
        if (stall_w[1] !== 1'b0) $display("FAIL lat3_release got stall=%b want 0", stall_w[1]);
        else pass_cnt++;
        total_cnt++;
        if (fd_w[1][31:0] !== 32'hBEEF || miss_w[1] !== 1'b0)
            $display("FAIL lat3_capture got d=%h miss=%b want d=0000beef miss=0", fd_w[1][31:0], miss_w[1]);
        else pass_cnt++;
        clr_in();
        e_rf_wena = 1; e_is_load = 1; e_rf_waddr = 5'd9;
        id_valid = 1; id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
        tick();
        clr_in();
        tick(); tick(); tick();
        total_cnt++;
        if (miss_w[1] !== 1'b1 || stall_w[1] !== 1'b0)
            $display("FAIL lat3_miss got miss=%b stall=%b want miss=1 stall=0", miss_w[1], stall_w[1]);
        else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++;
        if (miss_w[1] !== 1'b1) $display("FAIL lat3_miss_sticky got %b want 1", miss_w[1]);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (miss_w[1] !== 1'b0) $display("FAIL lat3_miss_reset got %b want 0", miss_w[1]);
        else pass_cnt++;
    endtask

    task automatic test_hilo();
        do_reset();
        id_valid = 1; id_rd_hi = 1;
        e_hi_wena = 1; e_hi_wdata = 32'h1234; m_hi_wena = 1; m_hi_wdata = 32'h5678;
        tick();
        total_cnt++;
        if (hi_w[0] !== 32'h1234 || hif_w[0] !== 1'b1)
            $display("FAIL hi_exe got hi=%h f=%b want hi=00001234 f=1", hi_w[0], hif_w[0]);
        else pass_cnt++;
        clr_in();
        id_valid = 1; id_rd_lo = 1; m_lo_wena = 1; m_lo_wdata = 32'h9;
        tick();
        total_cnt++;
        if (lo_w[0] !== 32'h9 || lof_w[0] !== 1'b1)
            $display("FAIL lo_mem got lo=%h f=%b want lo=00000009 f=1", lo_w[0], lof_w[0]);
        else pass_cnt++;
        total_cnt++;
        if (hif_w[0] !== 1'b0 || hi_w[0] !== 32'h1234)
            $display("FAIL hi_hold got hi=%h f=%b want hi=00001234 f=0", hi_w[0], hif_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_wait();
        logic [OW-1:0] obs;
        do_reset();
        e_rf_wena = 1; e_is_load = 1; e_rf_waddr = 5'd7; e_rf_wdata = 32'h77;
        id_valid = 1; id_src_addr = {5'd0, 5'd7}; id_src_used = 2'b01;
        tick();
        clr_in();
        tick();
        rst = 1;
        tick();
        rst = 0;
        obs = {stall_w[1], miss_w[1], fv_w[1], fd_w[1], hif_w[1], hi_w[1], lof_w[1], lo_w[1]};
        total_cnt++;
        if (obs !== '0) $display("FAIL rst_wait_outputs got %h want 0", obs);
        else pass_cnt++;
        e_rf_wena = 1; e_is_load = 1; e_rf_waddr = 5'd6;
        id_valid = 1; id_src_addr = {5'd0, 5'd6}; id_src_used = 2'b01;
        tick();
        total_cnt++;
        if (stall_w[1] !== 1'b1) $display("FAIL rst_wait_restall got %b want 1", stall_w[1]);
        else pass_cnt++;
        clr_in();
        tick(); tick();
        m_rf_wena = 1; m_rf_waddr = 5'd6; m_rf_wdata = 32'hC0DE;
        tick();
        total_cnt++;
        if (stall_w[1] !== 1'b0 || fd_w[1][31:0] !== 32'hC0DE || miss_w[1] !== 1'b0)
            $display("FAIL rst_wait_capture got stall=%b d=%h miss=%b want stall=0 d=0000c0de miss=0",
                     stall_w[1], fd_w[1][31:0], miss_w[1]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, exp;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            id_valid    = ($urandom_range(0, 7) != 0);
            id_src_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_src_used = 2'($urandom);
            id_rd_hi    = 1'($urandom); id_rd_lo = 1'($urandom);
            e_rf_wena   = 1'($urandom); e_rf_waddr = 5'($urandom_range(0, 3));
            e_rf_wdata  = $urandom;     e_is_load = ($urandom_range(0, 3) == 0);
            e_hi_wena   = 1'($urandom); e_hi_wdata = $urandom;
            e_lo_wena   = 1'($urandom); e_lo_wdata = $urandom;
            m_rf_wena   = ($urandom_range(0, 3) != 0); m_rf_waddr = 5'($urandom_range(0, 3));
            m_rf_wdata  = $urandom;
            m_hi_wena   = 1'($urandom); m_hi_wdata = $urandom;
            m_lo_wena   = 1'($urandom); m_lo_wdata = $urandom;
            tick();
            for (int k = 0; k < 2; k++) begin
                obs = {stall_w[k], miss_w[k], fv_w[k], fd_w[k], hif_w[k], hi_w[k], lof_w[k], lo_w[k]};
                exp = {mstall[k], mmiss[k], mfv[k], mfd[k], mhif[k], mhi[k], mlof[k], mlo[k]};
                total_cnt++;
                if (obs !== exp) $display("FAIL random[%0d] inst%0d got %h want %h", n, k, obs, exp);
                else pass_cnt++;
            end
        end
        rst = 0;
    endtask

    initial begin
        clr_in();
        rst = 1;
        test_reset();
        test_alu_fwd();
        test_priority();
        test_load_use_lat1();
        test_load_use_lat3();
        test_hilo();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
